// File: rtl/vending_machine_multi_if.sv
// Coin-acceptor / dispenser bus of the multi-product vending controller.
// refund_req exists only when VM_REFUND_EN is defined.
interface vending_machine_multi_if #(
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned CREDIT_W = 8
) ();

  logic [1:0]          in;
  logic [SEL_W-1:0]    sel;
  logic                sel_valid;
`ifdef VM_REFUND_EN
  logic                refund_req;
`endif
  logic                out;
  logic [SEL_W-1:0]    item;
  logic [1:0]          change;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic                coin_reject;

  modport master (
    output in, sel, sel_valid,
`ifdef VM_REFUND_EN
    output refund_req,
`endif
    input  out, item, change, credit, busy, coin_reject
  );

  modport slave (
    input  in, sel, sel_valid,
`ifdef VM_REFUND_EN
    input  refund_req,
`endif
    output out, item, change, credit, busy, coin_reject
  );

endinterface

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: three coin denominations, per-item prices,
// greedy one-coin-per-cycle change. Optional refund request behind VM_REFUND_EN.
module vending_machine_multi #(
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned COIN1_VAL  = 5,
  parameter int unsigned COIN2_VAL  = 10,
  parameter int unsigned COIN3_VAL  = 25,
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned BASE_PRICE = 15,
  parameter int unsigned PRICE_STEP = 5,
  parameter int unsigned MAX_CREDIT = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vending_machine_multi_if.slave  vm_if
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCredit = 2'd1;
  localparam logic [1:0] StVend   = 2'd2;
  localparam logic [1:0] StChange = 2'd3;

  localparam logic [CREDIT_W-1:0] Coin1Val  = CREDIT_W'(COIN1_VAL);
  localparam logic [CREDIT_W-1:0] Coin2Val  = CREDIT_W'(COIN2_VAL);
  localparam logic [CREDIT_W-1:0] Coin3Val  = CREDIT_W'(COIN3_VAL);
  localparam logic [CREDIT_W:0]   MaxCredit = (CREDIT_W+1)'(MAX_CREDIT);

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'd1:    return Coin1Val;
      2'd2:    return Coin2Val;
      2'd3:    return Coin3Val;
      default: return '0;
    endcase
  endfunction

  // Largest coin not exceeding amt; prices are multiples of COIN1 so this always drains.
  function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] amt);
    if (amt >= Coin3Val)      return 2'd3;
    else if (amt >= Coin2Val) return 2'd2;
    else if (amt >= Coin1Val) return 2'd1;
    else                      return 2'd0;
  endfunction

  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] k);
    return CREDIT_W'(BASE_PRICE + 32'(k) * PRICE_STEP);
  endfunction

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                out_q, out_d;
  logic [SEL_W-1:0]    item_q, item_d;
  logic [1:0]          change_q, change_d;
  logic                busy_q, busy_d;
  logic                reject_q, reject_d;

  logic                coin_present;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_fits;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_in_range;
  logic                buy_ok;
  logic                refund_go;
  logic [1:0]          change_code;
  logic [CREDIT_W-1:0] change_amt;

  assign coin_present = |vm_if.in;
  assign credit_sum   = {1'b0, credit_q} + {1'b0, coin_value(vm_if.in)};
  assign coin_fits    = credit_sum <= MaxCredit;
  assign sel_price    = price_of(vm_if.sel);
  assign sel_in_range = 32'(vm_if.sel) < NUM_ITEMS;
  assign buy_ok       = vm_if.sel_valid && sel_in_range && (credit_q >= sel_price);
  assign change_code  = greedy_coin(credit_q);
  assign change_amt   = coin_value(change_code);

`ifdef VM_REFUND_EN
  assign refund_go = vm_if.refund_req && (credit_q != '0);
`else
  assign refund_go = 1'b0;
`endif

  // Outputs are registered alongside the state, so they describe the state being entered.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    out_d    = 1'b0;
    item_d   = '0;
    change_d = 2'd0;
    busy_d   = 1'b0;
    reject_d = 1'b0;

    case (state_q)
      StIdle, StCredit: begin
        if (refund_go) begin
          state_d  = StChange;
          change_d = change_code;
          credit_d = credit_q - change_amt;
          busy_d   = 1'b1;
          reject_d = coin_present;
        end else if (buy_ok) begin
          state_d  = StVend;
          out_d    = 1'b1;
          item_d   = vm_if.sel;
          credit_d = credit_q - sel_price;
          busy_d   = 1'b1;
          reject_d = coin_present;
        end else begin
          if (coin_present) begin
            if (coin_fits) begin
              credit_d = credit_sum[CREDIT_W-1:0];
            end else begin
              reject_d = 1'b1;
            end
          end
          state_d = (credit_d != '0) ? StCredit : StIdle;
        end
      end

      // VEND and CHANGE share the drain step: credit_q already holds the remainder.
      default: begin
        reject_d = coin_present;
        if (credit_q != '0) begin
          state_d  = StChange;
          change_d = change_code;
          credit_d = credit_q - change_amt;
          busy_d   = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      credit_q <= '0;
      out_q    <= 1'b0;
      item_q   <= '0;
      change_q <= 2'd0;
      busy_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      out_q    <= out_d;
      item_q   <= item_d;
      change_q <= change_d;
      busy_q   <= busy_d;
      reject_q <= reject_d;
    end
  end

  assign vm_if.out         = out_q;
  assign vm_if.item        = item_q;
  assign vm_if.change      = change_q;
  assign vm_if.credit      = credit_q;
  assign vm_if.busy        = busy_q;
  assign vm_if.coin_reject = reject_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_vending_machine_multi;

  localparam int SEL_W     = 2;
  localparam int CREDIT_W  = 8;
  localparam int NUM_ITEMS = 4;
  localparam int MAX_CRED  = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vending_machine_multi_if #(.SEL_W(SEL_W), .CREDIT_W(CREDIT_W)) vm_if ();

  vending_machine_multi #(
    .CREDIT_W  (CREDIT_W),
    .COIN1_VAL (5),
    .COIN2_VAL (10),
    .COIN3_VAL (25),
    .NUM_ITEMS (NUM_ITEMS),
    .SEL_W     (SEL_W),
    .BASE_PRICE(15),
    .PRICE_STEP(5),
    .MAX_CREDIT(MAX_CRED)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .vm_if(vm_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int e_out, input int e_item,
                            input int e_chg, input int e_cred, input int e_busy,
                            input int e_rej);
    chk({tag, ".out"},         32'(vm_if.out),         e_out);
    chk({tag, ".item"},        32'(vm_if.item),        e_item);
    chk({tag, ".change"},      32'(vm_if.change),      e_chg);
    chk({tag, ".credit"},      32'(vm_if.credit),      e_cred);
    chk({tag, ".busy"},        32'(vm_if.busy),        e_busy);
    chk({tag, ".coin_reject"}, 32'(vm_if.coin_reject), e_rej);
  endtask

  task automatic drive(input int in_c, input int sel, input int sv, input int rf);
    vm_if.in        = 2'(in_c);
    vm_if.sel       = SEL_W'(sel);
    vm_if.sel_valid = (sv != 0);
`ifdef VM_REFUND_EN
    vm_if.refund_req = (rf != 0);
`else
    if (rf != 0) $display("note: refund requested in a build without refund support");
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int in_c; int sel; int sv;
    int e_out; int e_item; int e_chg; int e_cred; int e_busy; int e_rej;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(int in_c, int sel, int sv, int e_out, int e_item, int e_chg,
                              int e_cred, int e_busy, int e_rej);
    vecs.push_back('{in_c, sel, sv, e_out, e_item, e_chg, e_cred, e_busy, e_rej});
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       out;
    logic [1:0] item;
    logic [1:0] chg;
    logic [7:0] credit;
    logic       busy;
  } rec_t;

  rec_t mq[$];   // outputs already committed for coming cycles
  int   m_credit;

  function automatic int coin_val(int code);
    case (code)
      1: return 5;
      2: return 10;
      3: return 25;
      default: return 0;
    endcase
  endfunction

  function automatic int price(int k);
    return 15 + 5 * k;
  endfunction

  function automatic void sched_change(int amt);
    int r = amt;
    int c;
    while (r > 0) begin
      c = (r >= 25) ? 3 : ((r >= 10) ? 2 : 1);
      r -= coin_val(c);
      mq.push_back('{out: 1'b0, item: 2'd0, chg: 2'(c), credit: 8'(r), busy: 1'b1});
    end
    mq.push_back('{out: 1'b0, item: 2'd0, chg: 2'd0, credit: 8'd0, busy: 1'b0});
  endfunction

  task automatic model_step(input int in_c, input int sel, input int sv, input int rf,
                            output rec_t e, output int rej);
    int r;
    rej = 0;
    if (mq.size() > 0) begin
      e   = mq.pop_front();
      rej = (in_c != 0);
    end else if (rf != 0 && m_credit > 0) begin
      sched_change(m_credit);
      m_credit = 0;
      e   = mq.pop_front();
      rej = (in_c != 0);
    end else if (sv != 0 && sel < NUM_ITEMS && m_credit >= price(sel)) begin
      r = m_credit - price(sel);
      e = '{out: 1'b1, item: 2'(sel), chg: 2'd0, credit: 8'(r), busy: 1'b1};
      sched_change(r);
      m_credit = 0;
      rej = (in_c != 0);
    end else begin
      if (in_c != 0) begin
        if (m_credit + coin_val(in_c) <= MAX_CRED) m_credit += coin_val(in_c);
        else rej = 1;
      end
      e = '{out: 1'b0, item: 2'd0, chg: 2'd0, credit: 8'(m_credit), busy: 1'b0};
    end
  endtask

  initial begin
    rec_t e;
    int   rej, in_c, sel, sv, rf;

    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    //  in sel sv   out item chg cred busy rej
    // single-coin purchase, exact price
    add(1, 0, 0,   0, 0, 0,  5, 0, 0);
    add(1, 0, 0,   0, 0, 0, 10, 0, 0);
    add(1, 0, 0,   0, 0, 0, 15, 0, 0);
    add(0, 0, 1,   1, 0, 0,  0, 1, 0);
    add(0, 0, 0,   0, 0, 0,  0, 0, 0);
    // one coin of change
    add(3, 0, 0,   0, 0, 0, 25, 0, 0);
    add(0, 1, 1,   1, 1, 0,  5, 1, 0);
    add(0, 0, 0,   0, 0, 1,  0, 1, 0);
    add(0, 0, 0,   0, 0, 0,  0, 0, 0);
    // two coins of change, largest first
    add(3, 0, 0,   0, 0, 0, 25, 0, 0);
    add(3, 0, 0,   0, 0, 0, 50, 0, 0);
    add(0, 0, 1,   1, 0, 0, 35, 1, 0);
    add(0, 0, 0,   0, 0, 3, 10, 1, 0);
    add(0, 0, 0,   0, 0, 2,  0, 1, 0);
    add(0, 0, 0,   0, 0, 0,  0, 0, 0);
    // insufficient credit ignored; same-cycle coin still credited
    add(2, 0, 0,   0, 0, 0, 10, 0, 0);
    add(0, 3, 1,   0, 0, 0, 10, 0, 0);
    add(2, 3, 1,   0, 0, 0, 20, 0, 0);
    add(2, 0, 0,   0, 0, 0, 30, 0, 0);
    add(0, 3, 1,   1, 3, 0,  0, 1, 0);
    add(0, 0, 0,   0, 0, 0,  0, 0, 0);
    // credit cap, rejects during purchase and change
    add(3, 0, 0,   0, 0, 0, 25, 0, 0);
    add(3, 0, 0,   0, 0, 0, 50, 0, 0);
    add(3, 0, 0,   0, 0, 0, 75, 0, 0);
    add(3, 0, 0,   0, 0, 0, 100, 0, 0);
    add(1, 0, 0,   0, 0, 0, 100, 0, 1);
    add(0, 0, 0,   0, 0, 0, 100, 0, 0);
    add(1, 1, 1,   1, 1, 0, 80, 1, 1);
    add(2, 0, 0,   0, 0, 3, 55, 1, 1);
    add(0, 0, 0,   0, 0, 3, 30, 1, 0);
    add(2, 0, 0,   0, 0, 3,  5, 1, 1);
    add(0, 0, 0,   0, 0, 1,  0, 1, 0);
    add(0, 0, 0,   0, 0, 0,  0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].in_c, vecs[i].sel, vecs[i].sv, 0);
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_item, vecs[i].e_chg,
                 vecs[i].e_cred, vecs[i].e_busy, vecs[i].e_rej);
    end

    // reset asserted mid-change clears everything without waiting for a clock
    drive(3, 0, 0, 0); tick();
    drive(3, 0, 0, 0); tick();
    drive(0, 0, 1, 0); tick();
    check_outs("rstseq.vend", 1, 0, 0, 35, 1, 0);
    drive(0, 0, 0, 0); tick();
    check_outs("rstseq.chg", 0, 0, 3, 10, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check_outs("rstseq.async", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check_outs("rstseq.after", 0, 0, 0, 0, 0, 0);

`ifdef VM_REFUND_EN
    // refund in idle ignored, coin that cycle still credited
    drive(1, 0, 0, 1); tick();
    check_outs("refund.idle", 0, 0, 0, 5, 0, 0);
    drive(3, 0, 0, 0); tick();
    drive(1, 0, 0, 0); tick();
    check_outs("refund.fill", 0, 0, 0, 35, 0, 0);
    drive(1, 0, 0, 0); tick();
    check_outs("refund.c40", 0, 0, 0, 40, 0, 0);
    drive(2, 0, 1, 1); tick();
    check_outs("refund.c3", 0, 0, 3, 15, 1, 1);
    drive(0, 0, 0, 0); tick();
    check_outs("refund.c2", 0, 0, 2, 5, 1, 0);
    tick();
    check_outs("refund.c1", 0, 0, 1, 0, 1, 0);
    tick();
    check_outs("refund.idle2", 0, 0, 0, 0, 0, 0);
`endif

    // randomized run against the model, from a clean reset
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mq.delete();
    m_credit = 0;
    for (int n = 0; n < 600; n++) begin
      in_c = ($urandom % 2 == 0) ? int'($urandom_range(1, 3)) : 0;
      sel  = int'($urandom_range(0, NUM_ITEMS - 1));
      sv   = ($urandom % 4 == 0) ? 1 : 0;
`ifdef VM_REFUND_EN
      rf   = ($urandom % 11 == 0) ? 1 : 0;
`else
      rf   = 0;
`endif
      drive(in_c, sel, sv, rf);
      model_step(in_c, sel, sv, rf, e, rej);
      tick();
      check_outs($sformatf("rand%0d", n), int'(e.out), int'(e.item), int'(e.chg),
                 int'(e.credit), int'(e.busy), rej);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
